// File: rtl/mem_fill_arbiter_if.sv
// mem_fill_arbiter_if
//   Bundles every handshake and bus signal of mem_fill_arbiter so the
//   arbiter, the two caches and the memory connect through one port.
//
//   Modports:
//     slave  - the arbiter side. It receives requests and memory read data,
//              and drives memory strobes and fill/ack returns.
//     master - the environment side (caches plus memory). Its directions are
//              the reverse of slave.
//
//   Signal groups:
//     I-cache fill : i_miss_req/i_miss_addr in; i_fill_* / i_busy out
//     D-cache fill : d_miss_req/d_miss_addr in; d_fill_* / d_busy out
//     D-cache store: d_wr_req/d_wr_addr/d_wr_data in; d_wr_ack out
//     Memory       : mem_addr/mem_enable/mem_wr/mem_wdata out;
//                    mem_rdata/mem_rdata_valid in
interface mem_fill_arbiter_if;
    logic        i_miss_req;
    logic [15:0] i_miss_addr;
    logic        d_miss_req;
    logic [15:0] d_miss_addr;
    logic        d_wr_req;
    logic [15:0] d_wr_addr;
    logic [15:0] d_wr_data;
    logic [15:0] mem_rdata;
    logic        mem_rdata_valid;

    logic [15:0] mem_addr;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] i_fill_data;
    logic [15:0] i_fill_addr;
    logic        i_fill_valid;
    logic        i_fill_done;
    logic        i_busy;
    logic [15:0] d_fill_data;
    logic [15:0] d_fill_addr;
    logic        d_fill_valid;
    logic        d_fill_done;
    logic        d_busy;
    logic        d_wr_ack;

    modport slave (
        input  i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
               d_wr_req, d_wr_addr, d_wr_data, mem_rdata, mem_rdata_valid,
        output mem_addr, mem_enable, mem_wr, mem_wdata,
               i_fill_data, i_fill_addr, i_fill_valid, i_fill_done, i_busy,
               d_fill_data, d_fill_addr, d_fill_valid, d_fill_done, d_busy,
               d_wr_ack
    );

    modport master (
        output i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
               d_wr_req, d_wr_addr, d_wr_data, mem_rdata, mem_rdata_valid,
        input  mem_addr, mem_enable, mem_wr, mem_wdata,
               i_fill_data, i_fill_addr, i_fill_valid, i_fill_done, i_busy,
               d_fill_data, d_fill_addr, d_fill_valid, d_fill_done, d_busy,
               d_wr_ack
    );
endinterface

// File: rtl/mem_fill_arbiter.sv
// mem_fill_arbiter
//   Shares one single-ported, pipelined main memory between the I-cache
//   fill path and the D-cache fill and store-through paths.
//   - A store takes one WRITE cycle, then one DONE cycle in which d_wr_ack
//     is pulsed.
//   - A fill issues the 8 block-aligned word addresses back to back. It
//     routes each returning word, tagged with its address, to the owning
//     cache. On the 8th word it pulses fill_done, then spends one DONE cycle.
//   - Grant priority in IDLE is d_wr_req > d_miss_req > i_miss_req.
//
//   Ports:
//     clk - clock
//     rst - synchronous active-high reset
//     bus - mem_fill_arbiter_if.slave. It carries the cache requests,
//           fill/ack returns and memory strobes.
//
//   Parameters:
//     MEM_LATENCY - cycles from address issue to the matching
//                   mem_rdata_valid
//     WORDS       - words per cache block. The design assumes 8, with the
//                   word index at addr[3:1].
module mem_fill_arbiter #(
    parameter int MEM_LATENCY = 4,
    parameter int WORDS       = 8
) (
    input  logic              clk,
    input  logic              rst,
    mem_fill_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(WORDS);
    localparam int CNT_W = IDX_W + 1;
    localparam int DRN_W = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] NUM_WORDS  = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(WORDS - 1);
    localparam logic [DRN_W-1:0] DRAIN_INIT = DRN_W'(MEM_LATENCY);

    typedef enum logic [1:0] {IDLE, WRITE, FILL, DONE} state_t;

    state_t           state, state_nxt;
    logic             owner_d, owner_nxt;   // 1: D-cache owns memory, 0: I-cache
    logic             wr_job, wr_job_nxt;   // current grant is a store-through
    logic [CNT_W-1:0] issue_cnt, issue_nxt;
    logic [CNT_W-1:0] rcv_cnt, rcv_nxt;
    logic [DRN_W-1:0] drain;
    logic             load_wr, load_base;
    logic [15:0]      base_nxt;
    logic [15:0]      base_addr, wr_addr, wr_data;
    logic             rd_accept;
    logic             busy, fill_valid, fill_done;
    logic [15:0]      fill_addr;

    // Address of word idx inside the block starting at base. The base has
    // its low 4 bits clear, so the add never carries out of bit 3.
    function automatic logic [15:0] word_addr(input logic [15:0] base,
                                              input logic [CNT_W-1:0] idx);
        return base + 16'({idx[IDX_W-1:0], 1'b0});
    endfunction

    // Control state. After reset, data still in the memory pipeline from an
    // aborted fill can arrive for up to MEM_LATENCY cycles. The drain counter
    // keeps such data from being taken as words of a new fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            wr_job    <= 1'b0;
            issue_cnt <= '0;
            rcv_cnt   <= '0;
            drain     <= DRAIN_INIT;
        end else begin
            state     <= state_nxt;
            owner_d   <= owner_nxt;
            wr_job    <= wr_job_nxt;
            issue_cnt <= issue_nxt;
            rcv_cnt   <= rcv_nxt;
            if (drain != '0) begin
                drain <= drain - 1'b1;
            end
        end
    end

    // Latched request payload. It is only meaningful while the matching
    // state is active, so it has no reset.
    always_ff @(posedge clk) begin
        if (load_base) begin
            base_addr <= base_nxt;
        end
        if (load_wr) begin
            wr_addr <= bus.d_wr_addr;
            wr_data <= bus.d_wr_data;
        end
    end

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner_d;
        wr_job_nxt = wr_job;
        issue_nxt  = issue_cnt;
        rcv_nxt    = rcv_cnt;
        load_wr    = 1'b0;
        load_base  = 1'b0;
        base_nxt   = bus.d_miss_addr & 16'hFFF0;
        busy       = 1'b0;
        fill_valid = 1'b0;
        fill_done  = 1'b0;
        fill_addr  = '0;
        rd_accept  = bus.mem_rdata_valid && (drain == '0) && (rcv_cnt < NUM_WORDS);

        bus.mem_addr   = '0;
        bus.mem_enable = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.mem_wdata  = '0;
        bus.d_wr_ack   = 1'b0;

        case (state)
            IDLE: begin
                issue_nxt = '0;
                rcv_nxt   = '0;
                if (bus.d_wr_req) begin
                    state_nxt  = WRITE;
                    owner_nxt  = 1'b1;
                    wr_job_nxt = 1'b1;
                    load_wr    = 1'b1;
                end else if (bus.d_miss_req) begin
                    state_nxt  = FILL;
                    owner_nxt  = 1'b1;
                    wr_job_nxt = 1'b0;
                    load_base  = 1'b1;
                end else if (bus.i_miss_req) begin
                    state_nxt  = FILL;
                    owner_nxt  = 1'b0;
                    wr_job_nxt = 1'b0;
                    load_base  = 1'b1;
                    base_nxt   = bus.i_miss_addr & 16'hFFF0;
                end
            end
            WRITE: begin
                busy           = 1'b1;
                bus.mem_enable = 1'b1;
                bus.mem_wr     = 1'b1;
                bus.mem_addr   = wr_addr;
                bus.mem_wdata  = wr_data;
                state_nxt      = DONE;
            end
            FILL: begin
                busy = 1'b1;
                // Issue runs unconditionally; memory is pipelined and never stalls.
                if (issue_cnt < NUM_WORDS) begin
                    bus.mem_enable = 1'b1;
                    bus.mem_addr   = word_addr(base_addr, issue_cnt);
                    issue_nxt      = issue_cnt + 1'b1;
                end
                if (rd_accept) begin
                    fill_valid = 1'b1;
                    fill_addr  = word_addr(base_addr, rcv_cnt);
                    rcv_nxt    = rcv_cnt + 1'b1;
                    if (rcv_cnt == LAST_WORD) begin
                        fill_done = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                // Requests are not sampled here. A requester may still hold
                // its req this cycle without being granted again.
                busy         = 1'b1;
                bus.d_wr_ack = wr_job;
                state_nxt    = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Route the generic fill/busy signals to the owner only. The other
        // cache always sees zeros.
        bus.i_busy       = busy & ~owner_d;
        bus.d_busy       = busy & owner_d;
        bus.i_fill_valid = fill_valid & ~owner_d;
        bus.d_fill_valid = fill_valid & owner_d;
        bus.i_fill_done  = fill_done & ~owner_d;
        bus.d_fill_done  = fill_done & owner_d;
        bus.i_fill_data  = (fill_valid & ~owner_d) ? bus.mem_rdata : 16'h0;
        bus.d_fill_data  = (fill_valid & owner_d) ? bus.mem_rdata : 16'h0;
        bus.i_fill_addr  = (fill_valid & ~owner_d) ? fill_addr : 16'h0;
        bus.d_fill_addr  = (fill_valid & owner_d) ? fill_addr : 16'h0;
    end
endmodule

// File: tb/tb_mem_fill_arbiter.sv
// tb_mem_fill_arbiter
//   Bench for mem_fill_arbiter. It contains a fixed-latency memory model, a
//   cache requester model and a transaction-level reference model. The
//   reference output is compared against the DUT every cycle. Directed
//   scenarios pin the model with literal values. A randomized phase follows.
`timescale 1ns/1ps
module tb_mem_fill_arbiter;
    localparam int LAT  = 4;
    localparam int MAXC = 4096;
    localparam int J_IDLE = 0, J_WRITE = 1, J_FILL = 2, J_DONE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_fill_arbiter_if bus();

    mem_fill_arbiter #(.MEM_LATENCY(LAT), .WORDS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic        ret_v [MAXC];
    logic [15:0] ret_d [MAXC];

    bit chk_en   = 1'b0;
    bit stray_en = 1'b0;
    bit rand_en  = 1'b0;
    bit rand_rst = 1'b0;
    int blk      = 0;
    int i_drop = 0, d_drop = 0, w_drop = 0;
    int i_extra = 0, d_extra = 0;

    // reference model state
    int          m_job = J_IDLE;
    bit          m_own_d = 1'b0;
    bit          m_wr = 1'b0;
    logic [15:0] m_base = '0, m_wa = '0, m_wd = '0;
    int          m_start = 0;
    int          m_got = 0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int t);
        while (cyc < t) step();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < MAXC; i++) begin
            ret_v[i] = 1'b0;
            ret_d[i] = '0;
        end
        bus.i_miss_req = 0; bus.i_miss_addr = '0;
        bus.d_miss_req = 0; bus.d_miss_addr = '0;
        bus.d_wr_req = 0; bus.d_wr_addr = '0; bus.d_wr_data = '0;
        bus.mem_rdata = '0; bus.mem_rdata_valid = 0;
    end

    // Model transition at each edge, then memory returns for the new cycle.
    always @(posedge clk) begin
        if (rst) begin
            m_job = J_IDLE;
            m_got = 0;
        end else begin
            case (m_job)
                J_IDLE: begin
                    if (bus.d_wr_req) begin
                        m_job = J_WRITE; m_wa = bus.d_wr_addr; m_wd = bus.d_wr_data;
                        m_own_d = 1'b1; m_wr = 1'b1;
                    end else if (bus.d_miss_req) begin
                        m_job = J_FILL; m_base = bus.d_miss_addr & 16'hFFF0;
                        m_own_d = 1'b1; m_wr = 1'b0; m_start = cyc + 1; m_got = 0;
                    end else if (bus.i_miss_req) begin
                        m_job = J_FILL; m_base = bus.i_miss_addr & 16'hFFF0;
                        m_own_d = 1'b0; m_wr = 1'b0; m_start = cyc + 1; m_got = 0;
                    end
                end
                J_WRITE: m_job = J_DONE;
                J_FILL: begin
                    if (bus.mem_rdata_valid) begin
                        m_got++;
                        if (m_got == 8) m_job = J_DONE;
                    end
                end
                default: m_job = J_IDLE;
            endcase
        end
        cyc = cyc + 1;
        #1;
        if (ret_v[cyc]) begin
            bus.mem_rdata_valid = 1'b1;
            bus.mem_rdata = ret_d[cyc];
        end else if (stray_en && m_job != J_FILL && $urandom_range(0, 7) == 0) begin
            bus.mem_rdata_valid = 1'b1;
            bus.mem_rdata = 16'($urandom);
        end else begin
            bus.mem_rdata_valid = 1'b0;
            bus.mem_rdata = 16'($urandom);
        end
    end

    // Compare process, memory address capture and requester completion tracking.
    always @(negedge clk) begin
        logic [15:0] e_maddr, e_wdata, e_idata, e_iaddr, e_ddata, e_daddr;
        logic e_en, e_wr, e_iv, e_idn, e_ib, e_dv, e_ddn, e_db, e_ack;
        logic [104:0] act_v, exp_v;
        int idx;
        e_maddr = '0; e_wdata = '0; e_idata = '0; e_iaddr = '0; e_ddata = '0; e_daddr = '0;
        e_en = 0; e_wr = 0; e_iv = 0; e_idn = 0; e_ib = 0; e_dv = 0; e_ddn = 0; e_db = 0; e_ack = 0;
        if (chk_en) begin
            case (m_job)
                J_WRITE: begin
                    e_en = 1; e_wr = 1; e_maddr = m_wa; e_wdata = m_wd; e_db = 1;
                end
                J_FILL: begin
                    if (m_own_d) e_db = 1; else e_ib = 1;
                    idx = cyc - m_start;
                    if (idx >= 0 && idx < 8) begin
                        e_en = 1;
                        e_maddr = m_base + 16'(2 * idx);
                    end
                    if (bus.mem_rdata_valid) begin
                        if (m_own_d) begin
                            e_dv = 1; e_ddata = bus.mem_rdata;
                            e_daddr = m_base + 16'(2 * m_got); e_ddn = (m_got == 7);
                        end else begin
                            e_iv = 1; e_idata = bus.mem_rdata;
                            e_iaddr = m_base + 16'(2 * m_got); e_idn = (m_got == 7);
                        end
                    end
                end
                J_DONE: begin
                    if (m_own_d) e_db = 1; else e_ib = 1;
                    e_ack = m_wr;
                end
                default: ;
            endcase
            exp_v = {e_en, e_wr, e_maddr, e_wdata, e_iv, e_idn, e_ib, e_idata, e_iaddr,
                     e_dv, e_ddn, e_db, e_ddata, e_daddr, e_ack};
            act_v = {bus.mem_enable, bus.mem_wr, (e_en ? bus.mem_addr : 16'h0),
                     (e_wr ? bus.mem_wdata : 16'h0),
                     bus.i_fill_valid, bus.i_fill_done, bus.i_busy, bus.i_fill_data, bus.i_fill_addr,
                     bus.d_fill_valid, bus.d_fill_done, bus.d_busy, bus.d_fill_data, bus.d_fill_addr,
                     bus.d_wr_ack};
            check($sformatf("cycle %0d outputs", cyc), 128'(act_v), 128'(exp_v));
        end
        if (bus.mem_enable === 1'b1 && bus.mem_wr === 1'b0 && cyc + LAT < MAXC) begin
            ret_v[cyc + LAT] = 1'b1;
            ret_d[cyc + LAT] = mem_word(bus.mem_addr);
        end
        if (bus.i_fill_done === 1'b1) i_drop = 1 + i_extra;
        if (bus.d_fill_done === 1'b1) d_drop = 1 + d_extra;
        if (bus.d_wr_ack === 1'b1) w_drop = 1;
    end

    // Requesters: drop req after completion. In the random phase they also
    // raise new requests and occasionally reset.
    always @(posedge clk) begin
        #1;
        if (i_drop > 0) begin i_drop--; if (i_drop == 0) bus.i_miss_req = 0; end
        if (d_drop > 0) begin d_drop--; if (d_drop == 0) bus.d_miss_req = 0; end
        if (w_drop > 0) begin w_drop--; if (w_drop == 0) bus.d_wr_req = 0; end
        if (rand_rst) begin
            rst = 1'b0;
            rand_rst = 1'b0;
        end else if (rand_en && $urandom_range(0, 399) == 0) begin
            rst = 1'b1;
            rand_rst = 1'b1;
            bus.i_miss_req = 0; bus.d_miss_req = 0; bus.d_wr_req = 0;
            i_drop = 0; d_drop = 0; w_drop = 0;
            blk = 8;
        end
        if (blk > 0) begin
            blk--;
        end else if (rand_en && !rand_rst) begin
            if (!bus.d_wr_req && w_drop == 0 && $urandom_range(0, 15) == 0) begin
                bus.d_wr_addr = 16'($urandom); bus.d_wr_data = 16'($urandom); bus.d_wr_req = 1;
            end
            if (!bus.d_miss_req && d_drop == 0 && $urandom_range(0, 11) == 0) begin
                d_extra = int'($urandom_range(0, 1));
                bus.d_miss_addr = 16'($urandom); bus.d_miss_req = 1;
            end
            if (!bus.i_miss_req && i_drop == 0 && $urandom_range(0, 11) == 0) begin
                i_extra = int'($urandom_range(0, 1));
                bus.i_miss_addr = 16'($urandom); bus.i_miss_req = 1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b;
        repeat (3) step();
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset mem_enable", 128'(bus.mem_enable), 128'(1'b0));
        check("reset busy", 128'({bus.i_busy, bus.d_busy, bus.d_wr_ack}), 128'(3'b000));

        // stray valid in IDLE
        step();
        b = cyc + 1;
        ret_v[b] = 1'b1; ret_d[b] = 16'h7777;
        go(b);
        check("idle stray fill_valid", 128'({bus.i_fill_valid, bus.d_fill_valid, bus.d_busy}), 128'(3'b000));

        // D miss at 0x1236, held one cycle into DONE, 9th valid in DONE
        step(); b = cyc;
        d_extra = 1;
        bus.d_miss_addr = 16'h1236; bus.d_miss_req = 1;
        ret_v[b + 13] = 1'b1; ret_d[b + 13] = 16'h9999;
        go(b + 1);
        check("d first mem_addr", 128'({bus.mem_enable, bus.mem_addr}), 128'({1'b1, 16'h1230}));
        check("d busy at start", 128'({bus.d_busy, bus.i_busy}), 128'(2'b10));
        go(b + 5);
        check("d first fill_addr", 128'({bus.d_fill_valid, bus.d_fill_addr}), 128'({1'b1, 16'h1230}));
        go(b + 8);
        check("d last mem_addr", 128'({bus.mem_enable, bus.mem_addr}), 128'({1'b1, 16'h123E}));
        go(b + 9);
        check("d issue stopped", 128'(bus.mem_enable), 128'(1'b0));
        go(b + 12);
        check("d fill_done", 128'({bus.d_fill_done, bus.d_fill_addr, bus.d_fill_data}),
              128'({1'b1, 16'h123E, mem_word(16'h123E)}));
        go(b + 13);
        check("d DONE ignores 9th valid", 128'({bus.d_busy, bus.d_fill_valid, bus.d_fill_done, bus.mem_enable}),
              128'(4'b1000));
        go(b + 15);
        check("d no regrant", 128'({bus.d_busy, bus.mem_enable}), 128'(2'b00));
        d_extra = 0;

        // simultaneous store, D miss and I miss
        step(); b = cyc;
        bus.d_wr_addr = 16'h0040; bus.d_wr_data = 16'hBEEF; bus.d_wr_req = 1;
        bus.d_miss_addr = 16'h2000; bus.d_miss_req = 1;
        bus.i_miss_addr = 16'h0100; bus.i_miss_req = 1;
        go(b + 1);
        check("write cycle", 128'({bus.mem_enable, bus.mem_wr, bus.mem_addr, bus.mem_wdata}),
              128'({2'b11, 16'h0040, 16'hBEEF}));
        go(b + 2);
        check("write ack", 128'({bus.d_wr_ack, bus.d_busy}), 128'(2'b11));
        go(b + 4);
        check("d fill after write", 128'({bus.mem_addr, bus.d_busy, bus.i_busy}), 128'({16'h2000, 2'b10}));
        go(b + 18);
        check("i fill start", 128'({bus.mem_addr, bus.i_busy, bus.d_busy}), 128'({16'h0100, 2'b10}));
        go(b + 25);
        check("i fill last addr", 128'(bus.mem_addr), 128'(16'h010E));
        go(b + 29);
        check("i fill_done", 128'({bus.i_fill_done, bus.i_fill_addr}), 128'({1'b1, 16'h010E}));
        go(b + 31);

        // I miss at top of address space
        step(); b = cyc;
        bus.i_miss_addr = 16'hFFFE; bus.i_miss_req = 1;
        go(b + 1);
        check("top first addr", 128'({bus.mem_addr, bus.i_busy}), 128'({16'hFFF0, 1'b1}));
        go(b + 8);
        check("top last addr", 128'(bus.mem_addr), 128'(16'hFFFE));
        go(b + 12);
        check("top fill_done", 128'({bus.i_fill_done, bus.i_fill_addr}), 128'({1'b1, 16'hFFFE}));
        go(b + 14);

        // reset in the middle of a D fill, then a fresh fill
        step(); b = cyc;
        bus.d_miss_addr = 16'h4444; bus.d_miss_req = 1;
        while (cyc < b + 6) step();
        rst = 1'b1; bus.d_miss_req = 0;
        go(b + 6);
        check("pre-reset 2nd word", 128'({bus.d_fill_valid, bus.d_fill_addr}), 128'({1'b1, 16'h4442}));
        step(); rst = 1'b0;
        go(b + 7);
        check("after reset outputs", 128'({bus.d_busy, bus.mem_enable, bus.d_fill_valid, bus.d_fill_done}),
              128'(4'b0000));
        for (int t = 8; t <= 10; t++) begin
            go(b + t);
            check($sformatf("stale valid ignored %0d", t), 128'({bus.d_fill_valid, bus.i_fill_valid}), 128'(2'b00));
        end
        while (cyc < b + 12) step();
        bus.d_miss_req = 1;
        go(b + 13);
        check("refill first addr", 128'({bus.mem_addr, bus.mem_enable}), 128'({16'h4440, 1'b1}));
        go(b + 17);
        check("refill word 0", 128'({bus.d_fill_valid, bus.d_fill_addr}), 128'({1'b1, 16'h4440}));
        go(b + 26);

        // randomized traffic
        stray_en = 1'b1;
        rand_en  = 1'b1;
        repeat (2500) step();
        rand_en = 1'b0;
        repeat (80) step();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
